noc_pkt_master: RTL

NOC_PKT_MASTER -- requirements
Module: noc_pkt_master

---
 rtl/noc_pkg.sv | 12 +
 rtl/noc_pkt_master.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packet master: run-state encoding, response marker
// byte, statistics counter width and a saturating increment helper.
package noc_pkg;
   localparam int         CNT_W  = 16;
   localparam logic [7:0] MARKER = 8'hA5;

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_DONE} state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
   endfunction
endpackage

// File: rtl/noc_pkt_master.sv
// NoC traffic master: streams sequence-numbered packets round-robin to a range of PEs,
// keeps at most MAX_OUTSTANDING in flight, matches responses and reports run statistics.
module noc_pkt_master
   import noc_pkg::*;
#(
   parameter int DATAW           = 128,
   parameter int DESTW           = 4,
   parameter int NUM_DESTS       = 4,
   parameter int DEST_BASE       = 1,
   parameter int NUM_PACKETS     = 1,
   parameter int MAX_OUTSTANDING = 4,
   parameter int TIMEOUT         = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic             axis_tx_tvalid,
   input  logic             axis_tx_tready,
   output logic [DATAW-1:0] axis_tx_tdata,
   output logic [DESTW-1:0] axis_tx_tdest,
   input  logic             axis_rx_tvalid,
   output logic             axis_rx_tready,
   input  logic [DATAW-1:0] axis_rx_tdata,
   input  logic [DESTW-1:0] axis_rx_tdest,
   output logic [15:0]      tx_count,
   output logic [15:0]      rx_count,
   output logic [15:0]      err_count
);
   localparam int TOTAL = NUM_DESTS * NUM_PACKETS;
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam int IDX_W = (NUM_DESTS > 1) ? $clog2(NUM_DESTS) : 1;

   state_t           state_q, state_d;
   logic             tx_valid_q, tx_valid_d;
   logic [DATAW-1:0] tdata_q, tdata_d;
   logic [DESTW-1:0] tdest_q, tdest_d;
   logic [IDX_W-1:0] dest_idx_q, dest_idx_d;
   logic [CNT_W-1:0] tx_count_q, tx_count_d;
   logic [CNT_W-1:0] rx_count_q, rx_count_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;
   logic [OUT_W-1:0] outstanding_q, outstanding_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             timeout_q, timeout_d;
   logic             rx_ready_q, rx_ready_d;

   logic tx_hs, rx_hs, rx_ok, run_active, launch, last_tx, expire;
   logic unused_rx;

   function automatic logic [DATAW-1:0] pkt_data(input logic [CNT_W-1:0] seq);
      logic [DATAW-1:0] d;
      d = '0;
      d[15:0] = seq;
      d[DATAW-1 -: 8] = MARKER;
      return d;
   endfunction

   assign tx_hs      = tx_valid_q & axis_tx_tready;
   assign rx_hs      = axis_rx_tvalid & rx_ready_q;
   assign run_active = (state_q == ST_SEND) || (state_q == ST_WAIT);
   assign launch     = start & ~run_active;
   assign last_tx    = tx_hs && (tx_count_q == CNT_W'(TOTAL - 1));
   // A response only retires a packet if it looks like one we have actually sent.
   assign rx_ok      = rx_hs && run_active && (axis_rx_tdata[DATAW-1 -: 8] == MARKER)
                       && (axis_rx_tdata[15:0] < tx_count_q) && (outstanding_q != '0);
   assign expire     = (state_q == ST_WAIT) && !rx_hs && (timer_q == TMR_W'(TIMEOUT - 1));
   assign unused_rx  = ^{axis_rx_tdest, axis_rx_tdata[DATAW-9:16]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         tx_valid_q    <= 1'b0;
         tdata_q       <= '0;
         tdest_q       <= '0;
         dest_idx_q    <= '0;
         tx_count_q    <= '0;
         rx_count_q    <= '0;
         err_count_q   <= '0;
         outstanding_q <= '0;
         timer_q       <= '0;
         timeout_q     <= 1'b0;
         rx_ready_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         tx_valid_q    <= tx_valid_d;
         tdata_q       <= tdata_d;
         tdest_q       <= tdest_d;
         dest_idx_q    <= dest_idx_d;
         tx_count_q    <= tx_count_d;
         rx_count_q    <= rx_count_d;
         err_count_q   <= err_count_d;
         outstanding_q <= outstanding_d;
         timer_q       <= timer_d;
         timeout_q     <= timeout_d;
         rx_ready_q    <= rx_ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: if (start) state_d = ST_SEND;
         ST_SEND:          if (last_tx) state_d = ST_WAIT;
         ST_WAIT:          if ((outstanding_d == '0) || expire) state_d = ST_DONE;
      endcase
   end

   always_comb begin
      rx_ready_d  = 1'b1;
      tx_count_d  = sat_inc(tx_count_q, tx_hs);
      rx_count_d  = sat_inc(rx_count_q, rx_hs);
      err_count_d = sat_inc(err_count_q, rx_hs & ~rx_ok);
      outstanding_d = outstanding_q;
      if (tx_hs && !rx_ok)
         outstanding_d = outstanding_q + 1'b1;
      else if (!tx_hs && rx_ok)
         outstanding_d = outstanding_q - 1'b1;
      dest_idx_d = dest_idx_q;
      if (tx_hs)
         dest_idx_d = (dest_idx_q == IDX_W'(NUM_DESTS - 1)) ? '0 : dest_idx_q + 1'b1;
      timer_d   = ((state_q == ST_WAIT) && !rx_hs) ? timer_q + 1'b1 : '0;
      timeout_d = timeout_q | (expire && (outstanding_d != '0));
      tx_valid_d = 1'b0;
      tdata_d    = tdata_q;
      tdest_d    = tdest_q;
      // An offered beat is frozen until taken; a new one is only formed when the slot is free.
      if (state_q == ST_SEND && !last_tx) begin
         if (tx_hs || !tx_valid_q) begin
            tx_valid_d = (tx_count_d < CNT_W'(TOTAL)) && (outstanding_d < OUT_W'(MAX_OUTSTANDING));
            tdata_d    = pkt_data(tx_count_d);
            tdest_d    = DESTW'(DEST_BASE) + DESTW'(dest_idx_d);
         end else begin
            tx_valid_d = 1'b1;
         end
      end
      if (launch) begin
         tx_count_d    = '0;
         rx_count_d    = {{(CNT_W-1){1'b0}}, rx_hs};
         err_count_d   = {{(CNT_W-1){1'b0}}, rx_hs};
         outstanding_d = '0;
         dest_idx_d    = '0;
         timer_d       = '0;
         timeout_d     = 1'b0;
         tx_valid_d    = 1'b0;
      end
   end

   always_comb begin
      busy = run_active;
      done = (state_q == ST_DONE);
   end

   assign timeout        = timeout_q;
   assign axis_tx_tvalid = tx_valid_q;
   assign axis_tx_tdata  = tdata_q;
   assign axis_tx_tdest  = tdest_q;
   assign axis_rx_tready = rx_ready_q;
   assign tx_count       = tx_count_q;
   assign rx_count       = rx_count_q;
   assign err_count      = err_count_q;
endmodule
